// File: rtl/dma_burst_engine.sv
// rtl/dma_burst_engine.sv - single-descriptor DMA engine between the DRAM burst bus and GLB SRAM
module dma_burst_engine #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int GLB_AW    = 16,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_len_i,
   input  logic              req_dir_i,
   input  logic [GLB_AW-1:0] req_glb_addr_i,
   output logic              ar_valid_o,
   input  logic              ar_ready_i,
   output logic [ADDR_W-1:0] ar_addr_o,
   output logic [7:0]        ar_len_o,
   input  logic              r_valid_i,
   output logic              r_ready_o,
   input  logic [DATA_W-1:0] r_data_i,
   input  logic              r_last_i,
   output logic              aw_valid_o,
   input  logic              aw_ready_i,
   output logic [ADDR_W-1:0] aw_addr_o,
   output logic [7:0]        aw_len_o,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   output logic [DATA_W-1:0] w_data_o,
   output logic [3:0]        w_strb_o,
   output logic              w_last_o,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   output logic              glb_en_o,
   output logic              glb_we_o,
   output logic [GLB_AW-1:0] glb_addr_o,
   output logic [DATA_W-1:0] glb_wdata_o,
   output logic [3:0]        glb_wstrb_o,
   input  logic [DATA_W-1:0] glb_rdata_i,
   output logic              busy_o,
   output logic              dma_interrupt_o
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;        // DRAM byte address of the next burst
   logic [GLB_AW-1:0] glb_addr_q;    // next GLB word to write (read path) or to fetch (write path)
   logic [30:0]       beats_left_q;  // beats not yet moved on the data channel
   logic [8:0]        burst_q;       // beats in the current burst
   logic [8:0]        beat_q;        // data-channel beats done in the current burst
   logic [8:0]        issued_q;      // GLB reads issued in the current write burst
   logic [3:0]        tail_q;        // strobe for the final beat of the transfer
   logic              inflight_q;    // GLB read issued last cycle, data arrives this cycle

   // two-entry skid buffer between GLB read data and the W channel
   logic [DATA_W-1:0] fifo_mem [0:1];
   logic              fifo_wp, fifo_rp;
   logic [1:0]        fifo_cnt;

   logic [10:0] to_4k;
   logic [30:0] cap_beats, burst_full;
   logic [8:0]  burst_calc, burst_m1;
   logic        accept, addr_fire, r_fire, w_fire, glb_issue, burst_end, last_beat;
   logic        unused;

   // Burst = min(remaining beats, MAX_BURST, beats left before the next 4KB page)
   assign to_4k      = 11'd1024 - {1'b0, addr_q[11:2]};
   assign cap_beats  = (beats_left_q < 31'(MAX_BURST)) ? beats_left_q : 31'(MAX_BURST);
   assign burst_full = ({20'd0, to_4k} < cap_beats) ? {20'd0, to_4k} : cap_beats;
   assign burst_calc = burst_full[8:0];
   assign burst_m1   = burst_calc - 9'd1;

   assign accept    = (state_q == IDLE) && req_valid_i;
   assign addr_fire = ((state_q == RD_ADDR) && ar_ready_i) || ((state_q == WR_ADDR) && aw_ready_i);
   assign r_fire    = (state_q == RD_DATA) && r_valid_i;
   assign w_fire    = (state_q == WR_DATA) && (fifo_cnt != 2'd0) && w_ready_i;
   assign burst_end = (beat_q == burst_q - 9'd1);
   assign last_beat = (beats_left_q == 31'd1);

   // Prefetch while the skid buffer (counting the read in flight) has room after this cycle's pop
   assign glb_issue = (state_q == WR_DATA) && (issued_q != burst_q) &&
                      (({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, w_fire}));

   // r_last_i is informational only; the internal beat counter decides burst ends
   assign unused = ^{r_last_i, burst_full[30:9], burst_m1[8]};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and output decode
   always_comb begin
      state_d         = state_q;
      req_ready_o     = 1'b0;
      ar_valid_o      = 1'b0;
      ar_addr_o       = '0;
      ar_len_o        = '0;
      r_ready_o       = 1'b0;
      aw_valid_o      = 1'b0;
      aw_addr_o       = '0;
      aw_len_o        = '0;
      w_valid_o       = 1'b0;
      w_data_o        = '0;
      w_strb_o        = '0;
      w_last_o        = 1'b0;
      b_ready_o       = 1'b0;
      glb_en_o        = 1'b0;
      glb_we_o        = 1'b0;
      glb_addr_o      = '0;
      glb_wdata_o     = '0;
      glb_wstrb_o     = '0;
      busy_o          = (state_q != IDLE);
      dma_interrupt_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i)
               state_d = (req_len_i == 32'd0) ? DONE : (req_dir_i ? WR_ADDR : RD_ADDR);
         end
         RD_ADDR: begin
            ar_valid_o = 1'b1;
            ar_addr_o  = addr_q;
            ar_len_o   = burst_m1[7:0];
            if (ar_ready_i) state_d = RD_DATA;
         end
         RD_DATA: begin
            r_ready_o = 1'b1;
            if (r_valid_i) begin
               glb_en_o    = 1'b1;
               glb_we_o    = 1'b1;
               glb_addr_o  = glb_addr_q;
               glb_wdata_o = r_data_i;
               glb_wstrb_o = last_beat ? tail_q : 4'b1111;
               if (burst_end) state_d = last_beat ? DONE : RD_ADDR;
            end
         end
         WR_ADDR: begin
            aw_valid_o = 1'b1;
            aw_addr_o  = addr_q;
            aw_len_o   = burst_m1[7:0];
            if (aw_ready_i) state_d = WR_DATA;
         end
         WR_DATA: begin
            if (glb_issue) begin
               glb_en_o   = 1'b1;
               glb_addr_o = glb_addr_q;
            end
            if (fifo_cnt != 2'd0) begin
               w_valid_o = 1'b1;
               w_data_o  = fifo_mem[fifo_rp];
               w_strb_o  = last_beat ? tail_q : 4'b1111;
               w_last_o  = burst_end;
            end
            if (w_fire && burst_end) state_d = WR_RESP;
         end
         WR_RESP: begin
            b_ready_o = 1'b1;
            if (b_valid_i) state_d = (beats_left_q == 31'd0) ? DONE : WR_ADDR;
         end
         DONE: begin
            dma_interrupt_o = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Descriptor capture, burst/beat bookkeeping and skid buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         glb_addr_q   <= '0;
         beats_left_q <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         issued_q     <= '0;
         tail_q       <= '0;
         inflight_q   <= 1'b0;
         fifo_mem[0]  <= '0;
         fifo_mem[1]  <= '0;
         fifo_wp      <= 1'b0;
         fifo_rp      <= 1'b0;
         fifo_cnt     <= '0;
      end else begin
         if (accept) begin
            addr_q       <= req_addr_i;
            glb_addr_q   <= req_glb_addr_i;
            beats_left_q <= {1'b0, req_len_i[31:2]} + {30'd0, |req_len_i[1:0]};
            case (req_len_i[1:0])
               2'd1:    tail_q <= 4'b0001;
               2'd2:    tail_q <= 4'b0011;
               2'd3:    tail_q <= 4'b0111;
               default: tail_q <= 4'b1111;
            endcase
         end
         if (addr_fire) begin
            addr_q   <= addr_q + ADDR_W'({burst_calc, 2'b00});
            burst_q  <= burst_calc;
            beat_q   <= '0;
            issued_q <= '0;
         end
         if (r_fire || w_fire) begin
            beat_q       <= beat_q + 9'd1;
            beats_left_q <= beats_left_q - 31'd1;
         end
         if (r_fire || glb_issue) glb_addr_q <= glb_addr_q + 1'b1;
         if (glb_issue) issued_q <= issued_q + 9'd1;
         inflight_q <= glb_issue;
         if (inflight_q) begin
            fifo_mem[fifo_wp] <= glb_rdata_i;
            fifo_wp           <= ~fifo_wp;
         end
         if (w_fire) fifo_rp <= ~fifo_rp;
         fifo_cnt <= fifo_cnt + {1'b0, inflight_q} - {1'b0, w_fire};
      end
   end

endmodule

// File: tb/tb_dma_burst_engine.sv
// tb/tb_dma_burst_engine.sv - scoreboard bench for dma_burst_engine
module tb_dma_burst_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o, req_dir_i;
   logic [31:0] req_addr_i, req_len_i;
   logic [15:0] req_glb_addr_i;
   logic        ar_valid_o, ar_ready_i;
   logic [31:0] ar_addr_o;
   logic [7:0]  ar_len_o;
   logic        r_valid_i, r_ready_o, r_last_i;
   logic [31:0] r_data_i;
   logic        aw_valid_o, aw_ready_i;
   logic [31:0] aw_addr_o;
   logic [7:0]  aw_len_o;
   logic        w_valid_o, w_ready_i, w_last_o;
   logic [31:0] w_data_o;
   logic [3:0]  w_strb_o;
   logic        b_valid_i, b_ready_o;
   logic        glb_en_o, glb_we_o;
   logic [15:0] glb_addr_o;
   logic [31:0] glb_wdata_o, glb_rdata_i;
   logic [3:0]  glb_wstrb_o;
   logic        busy_o, dma_interrupt_o;

   always #5 clk = ~clk;

   dma_burst_engine dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_len_i(req_len_i), .req_dir_i(req_dir_i), .req_glb_addr_i(req_glb_addr_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
      .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_last_i(r_last_i),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
      .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
      .w_last_o(w_last_o), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .glb_en_o(glb_en_o), .glb_we_o(glb_we_o), .glb_addr_o(glb_addr_o),
      .glb_wdata_o(glb_wdata_o), .glb_wstrb_o(glb_wstrb_o), .glb_rdata_i(glb_rdata_i),
      .busy_o(busy_o), .dma_interrupt_o(dma_interrupt_o)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } exp_t;

   exp_t        ar_q[$], aw_q[$], glb_q[$], w_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] glb_mem [0:65535];

   int          rd_bursts[$];
   int          rbeat = 0;
   int          rk = 0;
   logic [31:0] rseed = 0;
   int          b_pend = 0;
   bit          w_toggle = 0;
   bit          ev_ar, ev_r, ev_wlast, ev_b, ev_rd, w_stall;
   int          ev_ar_beats;
   logic [15:0] ev_rd_addr;
   int          cyc = 0, irq_cnt = 0, irq_cyc = -1, acc_cyc = -1, last_glb_cyc = -1;
   int          n_ar = 0, n_aw = 0, n_glb = 0, n_w = 0;
   bit          prev_irq = 0;
   logic        rdy_at_irq, rdy_after_irq;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Bus responder and GLB RAM: inputs change on the falling edge
   task automatic drive_slave();
      if (rst) begin
         rd_bursts.delete();
         rbeat = 0; b_pend = 0; w_stall = 0;
         r_valid_i = 0; r_last_i = 0; ar_ready_i = 0; aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0;
         return;
      end
      if (ev_rd) glb_rdata_i = glb_mem[ev_rd_addr];
      if (ev_ar) rd_bursts.push_back(ev_ar_beats);
      if (ev_r) begin
         rk++;
         rbeat++;
         if (rd_bursts.size() > 0 && rbeat == rd_bursts[0]) begin
            void'(rd_bursts.pop_front());
            rbeat = 0;
         end
      end
      if (ev_wlast) b_pend++;
      if (ev_b) b_pend--;
      r_valid_i  = (rd_bursts.size() > 0) && ($urandom_range(0, 3) != 0);
      r_data_i   = rseed + 32'(rk);
      r_last_i   = (rd_bursts.size() > 0) && (rbeat == rd_bursts[0] - 1);
      ar_ready_i = 1'($urandom_range(0, 1));
      aw_ready_i = 1'($urandom_range(0, 1));
      w_ready_i  = w_toggle ? ~w_ready_i : 1'b1;
      b_valid_i  = (b_pend > 0);
   endtask

   // Observes what the next rising edge will commit and checks it against the scoreboard
   task automatic monitor();
      exp_t e;
      ev_ar = 0; ev_r = 0; ev_wlast = 0; ev_b = 0; ev_rd = 0;
      if (rst) return;
      cyc++;
      if (w_stall) check("w_hold_valid", 64'(w_valid_o), 64'd1);
      w_stall = w_valid_o && !w_ready_i;
      if (ar_valid_o && ar_ready_i) begin
         n_ar++;
         ev_ar = 1;
         ev_ar_beats = int'(ar_len_o) + 1;
         if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
         else begin
            e = ar_q.pop_front();
            check("ar_addr", 64'(ar_addr_o), 64'(e.a));
            check("ar_len", 64'(ar_len_o), 64'(e.d));
         end
      end
      if (aw_valid_o && aw_ready_i) begin
         n_aw++;
         if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
         else begin
            e = aw_q.pop_front();
            check("aw_addr", 64'(aw_addr_o), 64'(e.a));
            check("aw_len", 64'(aw_len_o), 64'(e.d));
         end
      end
      if (r_valid_i && r_ready_o) ev_r = 1;
      if (glb_en_o) begin
         n_glb++;
         if (glb_we_o) begin
            last_glb_cyc = cyc;
            if (glb_q.size() == 0) check("glb_unexpected", 64'd1, 64'd0);
            else begin
               e = glb_q.pop_front();
               check("glb_addr", 64'(glb_addr_o), 64'(e.a));
               check("glb_data", 64'(glb_wdata_o), 64'(e.d));
               check("glb_strb", 64'(glb_wstrb_o), 64'(e.s));
            end
            for (int b = 0; b < 4; b++)
               if (glb_wstrb_o[b]) glb_mem[glb_addr_o][8*b +: 8] = glb_wdata_o[8*b +: 8];
         end else begin
            ev_rd = 1;
            ev_rd_addr = glb_addr_o;
         end
      end
      if (w_valid_o && w_ready_i) begin
         n_w++;
         if (w_last_o) ev_wlast = 1;
         if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
         else begin
            e = w_q.pop_front();
            check("w_data", 64'(w_data_o), 64'(e.d));
            check("w_strb", 64'(w_strb_o), 64'(e.s));
            check("w_last", 64'(w_last_o), 64'(e.l));
         end
      end
      if (b_valid_i && b_ready_o) ev_b = 1;
      if (req_valid_i && req_ready_o) acc_cyc = cyc;
      if (prev_irq) rdy_after_irq = req_ready_o;
      if (dma_interrupt_o) begin
         irq_cnt++;
         irq_cyc = cyc;
         rdy_at_irq = req_ready_o;
      end
      prev_irq = dma_interrupt_o;
   endtask

   always @(negedge clk) begin
      drive_slave();
      #1;
      monitor();
   end

   // Expected bursts and beats for one descriptor, from the page-split rule
   task automatic push_expect(input logic [31:0] a, input logic [31:0] len, input bit dir,
                              input logic [15:0] g, input logic [31:0] seed);
      int          beats, rem, idx, b, to4k;
      logic [31:0] cur;
      logic [3:0]  tail;
      exp_t        e;
      beats = int'((len + 32'd3) / 32'd4);
      tail  = (len % 4 == 0) ? 4'b1111 : (4'b1111 >> (4 - len % 4));
      rem = beats; cur = a; idx = 0;
      while (rem > 0) begin
         to4k = (4096 - int'(cur % 4096)) / 4;
         b = rem;
         if (b > 16) b = 16;
         if (b > to4k) b = to4k;
         e.a = cur; e.d = 32'(b - 1); e.s = 4'b0; e.l = 1'b0;
         if (dir) aw_q.push_back(e);
         else ar_q.push_back(e);
         for (int j = 0; j < b; j++) begin
            e.s = (idx == beats - 1) ? tail : 4'b1111;
            e.l = (j == b - 1);
            if (dir) begin
               e.a = 32'd0;
               e.d = glb_mem[g + 16'(idx)];
               w_q.push_back(e);
            end else begin
               e.a = 32'(g) + 32'(idx);
               e.d = seed + 32'(idx);
               glb_q.push_back(e);
            end
            idx++;
         end
         cur = cur + 32'(b * 4);
         rem = rem - b;
      end
   endtask

   task automatic start_desc(input logic [31:0] a, input logic [31:0] len, input bit dir,
                             input logic [15:0] g);
      bit acc = 0;
      @(negedge clk);
      req_addr_i = a; req_len_i = len; req_dir_i = dir; req_glb_addr_i = g;
      req_valid_i = 1'b1;
      for (int t = 0; t < 20; t++) begin
         #2;
         if (req_ready_o) begin
            acc = 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
      check("accept_timeout", 64'(acc), 64'd1);
      #2;
      check("busy_after_accept", 64'(busy_o), 64'd1);
      check("ready_while_busy", 64'(req_ready_o), 64'd0);
   endtask

   task automatic finish_desc(input int irq0);
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (irq_cnt != irq0) break;
      end
      repeat (4) @(negedge clk);
      check("irq_count", 64'(irq_cnt - irq0), 64'd1);
      check("ar_left", 64'(ar_q.size()), 64'd0);
      check("aw_left", 64'(aw_q.size()), 64'd0);
      check("glb_left", 64'(glb_q.size()), 64'd0);
      check("w_left", 64'(w_q.size()), 64'd0);
   endtask

   task automatic run_desc(input logic [31:0] a, input logic [31:0] len, input bit dir,
                           input logic [15:0] g, input logic [31:0] seed);
      int irq0;
      push_expect(a, len, dir, g, seed);
      rseed = seed;
      rk = 0;
      irq0 = irq_cnt;
      start_desc(a, len, dir, g);
      finish_desc(irq0);
   endtask

   initial begin
      int irq0, s_ar, s_aw, s_glb, s_w;
      rst = 1'b1;
      req_valid_i = 0; req_addr_i = 0; req_len_i = 0; req_dir_i = 0; req_glb_addr_i = 0;
      ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_last_i = 0; aw_ready_i = 0;
      w_ready_i = 0; b_valid_i = 0; glb_rdata_i = 0;
      for (int i = 0; i < 1024; i++) glb_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);

      repeat (3) @(negedge clk);
      #2;
      check("rst_req_ready", 64'(req_ready_o), 64'd1);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_ar_valid", 64'(ar_valid_o), 64'd0);
      check("rst_glb_en", 64'(glb_en_o), 64'd0);
      check("rst_irq", 64'(dma_interrupt_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("idle_req_ready", 64'(req_ready_o), 64'd1);
      check("idle_w_valid", 64'(w_valid_o), 64'd0);
      check("idle_aw_valid", 64'(aw_valid_o), 64'd0);

      // single aligned read burst; interrupt right after the last GLB write
      run_desc(32'h0000_1000, 32'd64, 1'b0, 16'd0, 32'hA100_0000);
      check("t1_irq_after_last_beat", 64'(irq_cyc - last_glb_cyc), 64'd1);

      // read with partial tail, two bursts
      run_desc(32'h0000_2000, 32'd102, 1'b0, 16'd20, 32'hB200_0000);

      // read straddling a 4KB page
      run_desc(32'h0000_0FF0, 32'd64, 1'b0, 16'd40, 32'hC300_0000);

      // write with w_ready toggling
      w_toggle = 1;
      run_desc(32'h0000_3000, 32'd32, 1'b1, 16'd100, 32'd0);
      w_toggle = 0;

      // write with partial tail across a page boundary
      run_desc(32'h0000_4FF8, 32'd10, 1'b1, 16'd300, 32'd0);

      // zero-length descriptor: no bus or GLB traffic, interrupt in the cycle after accept
      s_ar = n_ar; s_aw = n_aw; s_glb = n_glb; s_w = n_w;
      run_desc(32'h0000_6000, 32'd0, 1'b0, 16'd0, 32'd0);
      check("t5_no_ar", 64'(n_ar - s_ar), 64'd0);
      check("t5_no_aw", 64'(n_aw - s_aw), 64'd0);
      check("t5_no_glb", 64'(n_glb - s_glb), 64'd0);
      check("t5_no_w", 64'(n_w - s_w), 64'd0);
      check("t5_irq_after_accept", 64'(irq_cyc - acc_cyc), 64'd1);
      check("t5_ready_at_irq", 64'(rdy_at_irq), 64'd0);
      check("t5_ready_after_irq", 64'(rdy_after_irq), 64'd1);

      // reset in the middle of a read data phase
      push_expect(32'h0000_5000, 32'd64, 1'b0, 16'd200, 32'hD400_0000);
      rseed = 32'hD400_0000;
      rk = 0;
      irq0 = irq_cnt;
      start_desc(32'h0000_5000, 32'd64, 1'b0, 16'd200);
      for (int t = 0; t < 200; t++) begin
         if (glb_q.size() <= 12) break;
         @(negedge clk);
      end
      check("t6_reached_rd_data", 64'(glb_q.size() <= 12), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("t6_rst_r_ready", 64'(r_ready_o), 64'd0);
      check("t6_rst_glb_en", 64'(glb_en_o), 64'd0);
      check("t6_rst_busy", 64'(busy_o), 64'd0);
      check("t6_rst_irq", 64'(dma_interrupt_o), 64'd0);
      ar_q.delete(); aw_q.delete(); glb_q.delete(); w_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      check("t6_ready_after_release", 64'(req_ready_o), 64'd1);
      check("t6_idle_busy", 64'(busy_o), 64'd0);
      repeat (20) @(negedge clk);
      check("t6_no_irq", 64'(irq_cnt - irq0), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
